exmem_skid_stage: RTL and testbench
===================================

Name: exmem_skid_stage

Overview:
- Parametrised successor to the fixed EXE→MEM pipeline register.
- Carries a generic data payload plus a control-bit bundle between pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer lets back-pressure from MEM stall EXE without a combinational ready path; a synchronous flush squashes in-flight instructions.
- A saturating stall-cycle counter supports performance debug. Sits between the EXE and MEM stages of the five-stage CPU.

Parameters:
- DW, 101, payload width (w_addr 5 + w_data 32 + Rdata2 32 + PC 32).
- CW, 5, control width (memWrite, memRead, memToReg, wen, jal).
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  EXE presents a valid instruction.
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready.
- in_data  in  DW  payload from EXE.
- in_ctrl  in  CW  control bits from EXE.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM consumes the entry this cycle.
- out_data  out  DW  payload to MEM.
- out_ctrl  out  CW  control to MEM; forced 0 when out_valid=0.
- stall_cnt  out  CNTW  saturating count of back-pressure cycles.
- clr_cnt  in  1  synchronous clear of stall_cnt.

Behaviour:
- Storage:
  - main entry: main_v, main_data, main_ctrl.
  - skid entry: skid_v, skid_data, skid_ctrl.
  - out_valid=main_v, out_data=main_data, out_ctrl=main_ctrl; all registered.
- State encoding from {skid_v, main_v}: EMPTY=00, FULL=01, SKID=11. 10 is illegal and never reached.
- in_ready = !skid_v, registered. Accept = in_valid & in_ready. Drain = main_v & out_ready.
- Transitions (no flush, no rst):
  - EMPTY: accept → FULL, main<=in. No accept → stay EMPTY.
  - FULL, accept & drain → FULL, main<=in.
  - FULL, accept & !drain → SKID, skid<=in, main held.
  - FULL, !accept & drain → EMPTY.
  - FULL, !accept & !drain → hold.
  - SKID: no accept possible. Drain → FULL, main<=skid, skid_v<=0. Else hold.
- Bubble rule:
  - Whenever main_v becomes 0, main_ctrl is cleared to 0, so a bubble never asserts memWrite or wen.
  - main_data may retain its old value.
  - skid_ctrl is cleared when skid_v becomes 0.
- Flush:
  - Next state is EMPTY; main_ctrl=0, skid_ctrl=0; in_ready=1 on the following cycle.
  - Overrides accept and drain in the same cycle; a simultaneous input is dropped.
  - An out_ready handshake in the flush cycle still counts as consumed by MEM; MEM sees the pre-flush entry that cycle.
  - stall_cnt is unaffected.
- Reset:
  - Next state is EMPTY; all data and ctrl registers are 0.
  - in_ready=1 and stall_cnt=0 after reset.
  - Reset mid-operation discards both entries.
  - rst has priority over flush and clr_cnt.
- Stall counter:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNTW-1; no wrap.
  - clr_cnt has priority over increment, and the count becomes 0.
- Latency:
  - 1 cycle from accept to out_valid when EMPTY or draining.
  - Throughput is 1 per cycle with out_ready held high.
- Ordering: strict FIFO order, main before skid. No data is lost without a flush.

Test Plan:
1. Reset, then stream in_data=1..4 one per cycle with ctrl=5'b01011 and out_ready=1 → out_data=1..4 on consecutive cycles, each 1 cycle after accept; in_ready stays 1.
2. Accept A=0x0AA, deassert out_ready, present B=0x0BB → B captured in skid, in_ready=0 next cycle. Raise out_ready → A then B emitted in order; in_ready returns to 1.
3. Hold out_ready=0 with out_valid=1 for 70000 cycles at CNTW=16 → stall_cnt=0xFFFF, no wrap. Pulse clr_cnt during a stall cycle → stall_cnt=0.
4. Reach SKID state (A in main, B in skid), assert flush with in_valid=1 and C=0x0CC → next cycle out_valid=0, out_ctrl=0, in_ready=1; C is never emitted.
5. Stream with ctrl memWrite=1, then in_valid=0 → the first bubble cycle shows out_valid=0 and out_ctrl=5'b00000.
6. Assert rst while in SKID state with stall_cnt=37 → next cycle all outputs 0 except in_ready=1, and stall_cnt=0.

Source files
------------

// File: rtl/exmem_skid_stage.sv
// EXE->MEM pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush, and a saturating back-pressure cycle counter.
//
// state | meaning ({skid_v, main_v})
// EMPTY | 00: no entry held, in_ready=1
// FULL  | 01: main entry presented to MEM, in_ready=1
// SKID  | 11: main presented, skid holds the next entry, in_ready=0
module exmem_skid_stage #(
  parameter int DW   = 101,
  parameter int CW   = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [CW-1:0]   in_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [CW-1:0]   out_ctrl,
  output logic [CNTW-1:0] stall_cnt,
  input  logic            clr_cnt
);

  logic          main_v, skid_v;
  logic [DW-1:0] main_data, skid_data;
  logic [CW-1:0] main_ctrl, skid_ctrl;
  logic          accept, drain;

  // in_ready comes straight off the skid flop, so out_ready never reaches it
  assign in_ready  = ~skid_v;
  assign accept    = in_valid & in_ready;
  assign drain     = main_v & out_ready;

  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_data <= '0;
      skid_data <= '0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (skid_v) begin
      if (drain) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
        skid_v    <= 1'b0;
        skid_ctrl <= '0;
      end
    end else if (accept && (!main_v || drain)) begin
      main_v    <= 1'b1;
      main_data <= in_data;
      main_ctrl <= in_ctrl;
    end else if (accept) begin
      skid_v    <= 1'b1;
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
    end else if (drain) begin
      // bubble must never carry memWrite/wen
      main_v    <= 1'b0;
      main_ctrl <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Bench for exmem_skid_stage: a 2-deep queue model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_exmem_skid_stage;
  localparam int DW   = 101;
  localparam int CW   = 5;
  localparam int CNTW = 10;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready, clr_cnt;
  logic [DW-1:0]   in_data;
  logic [CW-1:0]   in_ctrl;
  logic            in_ready, out_valid;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ctrl;
  logic [CNTW-1:0] stall_cnt;

  exmem_skid_stage #(.DW(DW), .CW(CW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: a FIFO of capacity two; the stage accepts whenever there is room.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t q[$];
  int   mcnt = 0;
  bit   model_ok = 0;

  always @(posedge clk) begin : model
    bit   acc, drn;
    ent_t e;
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (clr_cnt) mcnt = 0;
      else if ((q.size() > 0) && !out_ready && (mcnt < CMAX)) mcnt++;
      if (flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) begin
          e.d = in_data;
          e.c = in_ctrl;
          q.push_back(e);
        end
      end
    end
    model_ok = 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("m_in_ready", 128'(in_ready), 128'(q.size() < 2));
      chk("m_stall_cnt", 128'(stall_cnt), 128'(mcnt));
      chk("m_out_ctrl", 128'(out_ctrl), (q.size() > 0) ? 128'(q[0].c) : 128'(0));
      if (q.size() > 0) chk("m_out_data", 128'(out_data), 128'(q[0].d));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; clr_cnt = 0;
    in_data = '0; in_ctrl = '0;
    cyc();
    rst = 0;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_stall", 128'(stall_cnt), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));

    // 1: streaming at full rate
    out_ready = 1; in_ctrl = 5'b01011;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1; in_data = DW'(k);
      cyc();
      chk("stream_data", 128'(out_data), 128'(k));
      chk("stream_valid", 128'(out_valid), 128'(1));
      chk("stream_ready", 128'(in_ready), 128'(1));
    end
    in_valid = 0;
    cyc();

    // 2: back-pressure fills the skid entry, then drains in order
    out_ready = 0; in_valid = 1; in_data = DW'('h0AA);
    cyc();
    in_data = DW'('h0BB);
    cyc();
    chk("skid_in_ready", 128'(in_ready), 128'(0));
    chk("skid_head", 128'(out_data), 128'('h0AA));
    in_valid = 0; out_ready = 1;
    cyc();
    chk("skid_second", 128'(out_data), 128'('h0BB));
    chk("skid_ready_back", 128'(in_ready), 128'(1));
    cyc();
    chk("skid_empty", 128'(out_valid), 128'(0));

    // 3: stall counter saturation and clear
    out_ready = 0; in_valid = 1; in_data = DW'('h011);
    cyc();
    in_valid = 0; clr_cnt = 1;
    cyc();
    clr_cnt = 0;
    chk("cnt_cleared", 128'(stall_cnt), 128'(0));
    repeat (CMAX + 80) cyc();
    chk("cnt_saturated", 128'(stall_cnt), 128'(CMAX));
    clr_cnt = 1;
    cyc();
    clr_cnt = 0;
    chk("cnt_clr_in_stall", 128'(stall_cnt), 128'(0));
    cyc();
    chk("cnt_restart", 128'(stall_cnt), 128'(1));
    out_ready = 1;
    cyc();

    // 4: flush from SKID drops held entries and the concurrent input
    out_ready = 0; in_valid = 1; in_data = DW'('h0AA); in_ctrl = 5'b11111;
    cyc();
    in_data = DW'('h0BB);
    cyc();
    in_data = DW'('h0CC); flush = 1;
    cyc();
    flush = 0; in_valid = 0;
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ctrl", 128'(out_ctrl), 128'(0));
    chk("flush_ready", 128'(in_ready), 128'(1));
    out_ready = 1;
    repeat (3) begin
      cyc();
      chk("flush_no_c", 128'(out_valid), 128'(0));
    end

    // 5: bubble after memWrite traffic carries no control bits
    in_ctrl = 5'b10000;
    for (int k = 1; k <= 2; k++) begin
      in_valid = 1; in_data = DW'(k + 'h20);
      cyc();
    end
    chk("mw_ctrl", 128'(out_ctrl), 128'(5'b10000));
    in_valid = 0;
    cyc();
    chk("bubble_valid", 128'(out_valid), 128'(0));
    chk("bubble_ctrl", 128'(out_ctrl), 128'(0));

    // 6: reset while in SKID with a non-zero stall count
    clr_cnt = 1; out_ready = 0; in_valid = 1; in_data = DW'('h0AA); in_ctrl = 5'b01011;
    cyc();
    clr_cnt = 0; in_data = DW'('h0BB);
    cyc();
    in_valid = 0;
    repeat (36) cyc();
    chk("pre_rst_cnt", 128'(stall_cnt), 128'(37));
    chk("pre_rst_ready", 128'(in_ready), 128'(0));
    rst = 1; in_valid = 1; in_data = DW'('h0DD); flush = 1; clr_cnt = 1;
    cyc();
    rst = 0; flush = 0; clr_cnt = 0; in_valid = 0;
    chk("rst6_valid", 128'(out_valid), 128'(0));
    chk("rst6_data", 128'(out_data), 128'(0));
    chk("rst6_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst6_ready", 128'(in_ready), 128'(1));
    chk("rst6_cnt", 128'(stall_cnt), 128'(0));

    // recovery after reset, including a flush while MEM is consuming
    out_ready = 1; in_valid = 1; in_data = DW'('h077);
    cyc();
    chk("recover_data", 128'(out_data), 128'('h077));
    in_data = DW'('h078); flush = 1;
    cyc();
    flush = 0; in_valid = 0;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
